// File: rtl/ex_stage_mc_pkg.sv
// Shared definitions for the mips_16 execute stage: ALU command codes,
// ID/EX and EX/MEM field positions, and execute FSM state encodings.
package ex_stage_mc_pkg;

    // Nine commands share a 3-bit field, so NC takes code 0 together with ADD.
    // A bubble has zero operands, so its sum is 0, which is the NC result.
    localparam logic [2:0] ALU_NC  = 3'd0;
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SL  = 3'd5;
    localparam logic [2:0] ALU_DIV = 3'd6;
    localparam logic [2:0] ALU_MOD = 3'd7;

    localparam int IDEX_CMD_HI  = 56;
    localparam int IDEX_CMD_LO  = 54;
    localparam int IDEX_SRC1_HI = 53;
    localparam int IDEX_SRC1_LO = 38;
    localparam int IDEX_SRC2_HI = 37;
    localparam int IDEX_SRC2_LO = 22;
    localparam int CTRL_HI      = 21;
    localparam int CTRL_WB_EN   = 4;
    localparam int CTRL_DEST_HI = 3;
    localparam int CTRL_DEST_LO = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } ex_state_e;

    function automatic logic is_div_cmd(input logic [2:0] cmd);
        return (cmd == ALU_DIV) || (cmd == ALU_MOD);
    endfunction

endpackage

// File: rtl/seq_divider_16.sv
// Iterative signed divider: magnitudes go through a restoring divider one bit
// per cycle, then signs are restored (quotient toward zero, remainder follows dividend).
module seq_divider_16 #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         last,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);
    localparam int CW = $clog2(W);

    logic          busy_q, busy_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  dvs_q, dvs_d;
    logic [W-1:0]  dvd_q, dvd_d;
    logic          q_neg_q, q_neg_d;
    logic          r_neg_q, r_neg_d;
    logic          dz_q, dz_d;

    logic [W:0]    trial;
    logic [W:0]    diff;
    logic          ge;

    assign busy  = busy_q;
    assign last  = busy_q && (cnt_q == CW'(W - 1));
    assign trial = {rem_q, quo_q[W-1]};
    assign diff  = trial - {1'b0, dvs_q};
    assign ge    = trial >= {1'b0, dvs_q};

    always_comb begin
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        dvd_d   = dvd_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dz_d    = dz_q;
        if (start) begin
            busy_d  = 1'b1;
            cnt_d   = '0;
            quo_d   = dividend[W-1] ? (~dividend + 1'b1) : dividend;
            rem_d   = '0;
            dvs_d   = divisor[W-1] ? (~divisor + 1'b1) : divisor;
            dvd_d   = dividend;
            q_neg_d = dividend[W-1] ^ divisor[W-1];
            r_neg_d = dividend[W-1];
            dz_d    = (divisor == '0);
        end else if (busy_q) begin
            quo_d = {quo_q[W-2:0], ge};
            rem_d = ge ? diff[W-1:0] : trial[W-1:0];
            cnt_d = cnt_q + 1'b1;
            if (last) begin
                busy_d = 1'b0;
            end
        end
    end

    // Divide by zero overrides the sign fixup: all-ones quotient, dividend as remainder.
    always_comb begin
        quotient  = dz_q ? '1 : (q_neg_q ? -quo_q : quo_q);
        remainder = dz_q ? dvd_q : (r_neg_q ? -rem_q : rem_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            dvd_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            dvd_q   <= dvd_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dz_q    <= dz_d;
        end
    end

endmodule

// File: rtl/ex_stage_mc.sv
// mips_16 execute stage: single-cycle ALU ops, plus DIV/MOD on a multi-cycle
// divider that stalls the front end until the result is ready.
module ex_stage_mc
    import ex_stage_mc_pkg::*;
#(
    parameter int DIV_BITS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [56:0] pipeline_reg_in,
    output logic [37:0] pipeline_reg_out,
    output logic        ex_stall,
    output logic [2:0]  ex_op_dest,
    output logic [1:0]  dbg_state
);
    logic [2:0]  cmd;
    logic [15:0] src1, src2;
    logic [21:0] ctrl_in;
    logic [15:0] alu_result;

    ex_state_e   state_q, state_d;
    logic [2:0]  cmd_q, cmd_d;
    logic [21:0] ctrl_q, ctrl_d;
    logic [37:0] out_q, out_d;

    logic        div_start, div_busy, div_last;
    logic [15:0] div_quo, div_rem;

    assign cmd              = pipeline_reg_in[IDEX_CMD_HI:IDEX_CMD_LO];
    assign src1             = pipeline_reg_in[IDEX_SRC1_HI:IDEX_SRC1_LO];
    assign src2             = pipeline_reg_in[IDEX_SRC2_HI:IDEX_SRC2_LO];
    assign ctrl_in          = pipeline_reg_in[CTRL_HI:0];
    assign pipeline_reg_out = out_q;
    assign dbg_state        = state_q;

    always_comb begin
        case (cmd)
            ALU_ADD: alu_result = src1 + src2;
            ALU_SUB: alu_result = src1 - src2;
            ALU_AND: alu_result = src1 & src2;
            ALU_OR:  alu_result = src1 | src2;
            ALU_XOR: alu_result = src1 ^ src2;
            ALU_SL:  alu_result = src1 << src2[3:0];
            default: alu_result = 16'h0000;
        endcase
    end

    // Stall decodes only state and alu_cmd; the operand bits never reach it.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        ctrl_d    = ctrl_q;
        out_d     = '0;
        ex_stall  = 1'b0;
        div_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_div_cmd(cmd)) begin
                    ex_stall  = 1'b1;
                    div_start = 1'b1;
                    cmd_d     = cmd;
                    ctrl_d    = ctrl_in;
                    state_d   = ST_CALC;
                end else begin
                    out_d = {alu_result, ctrl_in};
                end
            end
            ST_CALC: begin
                ex_stall = 1'b1;
                if (div_last || !div_busy) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_d   = {(cmd_q == ALU_MOD) ? div_rem : div_quo, ctrl_q};
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ex_op_dest = 3'd0;
        if (state_q != ST_IDLE) begin
            if (ctrl_q[CTRL_WB_EN]) ex_op_dest = ctrl_q[CTRL_DEST_HI:CTRL_DEST_LO];
        end else if (ctrl_in[CTRL_WB_EN]) begin
            ex_op_dest = ctrl_in[CTRL_DEST_HI:CTRL_DEST_LO];
        end
    end

    seq_divider_16 #(
        .W(DIV_BITS)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (src1),
        .divisor  (src2),
        .busy     (div_busy),
        .last     (div_last),
        .quotient (div_quo),
        .remainder(div_rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            ctrl_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            ctrl_q  <= ctrl_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: tb/tb_ex_stage_mc.sv
// Directed bench for ex_stage_mc: the driver queues the expected per-cycle view
// {stall, dest, pipeline_reg_out, state}; a negedge monitor pops and compares it.
module tb_ex_stage_mc;
    import ex_stage_mc_pkg::*;

    logic        clk;
    logic        rst;
    logic [56:0] pipeline_reg_in;
    logic [37:0] pipeline_reg_out;
    logic        ex_stall;
    logic [2:0]  ex_op_dest;
    logic [1:0]  dbg_state;

    logic [43:0] exp_q[$];
    logic [37:0] pend;
    int          n_cmp;
    int          n_fail;
    int          cyc;

    ex_stage_mc #(.DIV_BITS(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .pipeline_reg_in (pipeline_reg_in),
        .pipeline_reg_out(pipeline_reg_out),
        .ex_stall        (ex_stall),
        .ex_op_dest      (ex_op_dest),
        .dbg_state       (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        logic [43:0] e;
        logic [43:0] a;
        cyc <= cyc + 1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {ex_stall, ex_op_dest, pipeline_reg_out, dbg_state};
            n_cmp = n_cmp + 1;
            if (a !== e) begin
                n_fail = n_fail + 1;
                $display("FAIL ex_view cyc %0d: stall %0b want %0b, dest %0d want %0d, out %h want %h, state %0d want %0d",
                         cyc, a[43], e[43], a[42:40], e[42:40], a[39:2], e[39:2], a[1:0], e[1:0]);
            end
        end
    end

    function automatic logic [21:0] mk_ctrl(input logic we, input logic [15:0] data,
                                            input logic wb, input logic [2:0] dest,
                                            input logic mux);
        return {we, data, wb, dest, mux};
    endfunction

    function automatic logic [2:0] dest_of(input logic [21:0] c);
        return c[4] ? c[3:1] : 3'd0;
    endfunction

    // One clock: drive inputs after the edge and queue what this cycle should show.
    task automatic step(input logic [56:0] in_v, input logic rst_v, input logic e_stall,
                        input logic [2:0] e_dest, input ex_state_e e_state,
                        input logic [37:0] next_out);
        @(posedge clk);
        #1;
        rst             = rst_v;
        pipeline_reg_in = in_v;
        exp_q.push_back({e_stall, e_dest, pend, logic'(e_state[1]), logic'(e_state[0])});
        pend = next_out;
    endtask

    task automatic alu(input logic [2:0] cmd, input logic [15:0] s1, input logic [15:0] s2,
                       input logic [21:0] c, input logic [15:0] res);
        step({cmd, s1, s2, c}, 1'b0, 1'b0, dest_of(c), ST_IDLE, {res, c});
    endtask

    task automatic bubble();
        step(57'd0, 1'b0, 1'b0, 3'd0, ST_IDLE, 38'd0);
    endtask

    task automatic divop(input logic [2:0] cmd, input logic [15:0] s1, input logic [15:0] s2,
                         input logic [21:0] c, input logic [15:0] res);
        step({cmd, s1, s2, c}, 1'b0, 1'b1, dest_of(c), ST_IDLE, 38'd0);
        for (int i = 0; i < 16; i++) step(57'd0, 1'b0, 1'b1, dest_of(c), ST_CALC, 38'd0);
        step(57'd0, 1'b0, 1'b0, dest_of(c), ST_DONE, {res, c});
    endtask

    initial begin
        logic [21:0] c3;
        n_cmp           = 0;
        n_fail          = 0;
        cyc             = 0;
        pend            = 38'd0;
        rst             = 1'b1;
        pipeline_reg_in = 57'd0;
        c3              = mk_ctrl(1'b0, 16'h0000, 1'b1, 3'd3, 1'b0);

        step(57'd0, 1'b1, 1'b0, 3'd0, ST_IDLE, 38'd0);
        bubble();

        alu(ALU_ADD, 16'd7, 16'hFFFD, mk_ctrl(1'b0, 16'h0000, 1'b1, 3'd5, 1'b0), 16'd4);
        alu(ALU_SUB, 16'd5, 16'd9, mk_ctrl(1'b0, 16'h0000, 1'b1, 3'd2, 1'b1), 16'hFFFC);
        alu(ALU_AND, 16'hF0F0, 16'h0FF0, mk_ctrl(1'b0, 16'h0000, 1'b1, 3'd1, 1'b0), 16'h00F0);
        alu(ALU_OR, 16'hF0F0, 16'h0F0F, mk_ctrl(1'b0, 16'h0000, 1'b1, 3'd7, 1'b0), 16'hFFFF);
        alu(ALU_XOR, 16'hAAAA, 16'hFFFF, mk_ctrl(1'b0, 16'h0000, 1'b0, 3'd6, 1'b0), 16'h5555);
        alu(ALU_SL, 16'h0001, 16'h0013, mk_ctrl(1'b0, 16'h0000, 1'b1, 3'd4, 1'b0), 16'h0008);

        divop(ALU_DIV, 16'd100, 16'd7, c3, 16'h000E);
        divop(ALU_MOD, 16'hFF9C, 16'd7, c3, 16'hFFFE);
        divop(ALU_DIV, 16'h8000, 16'hFFFF, mk_ctrl(1'b0, 16'h0000, 1'b1, 3'd6, 1'b0), 16'h8000);
        divop(ALU_DIV, 16'd5, 16'd0, c3, 16'hFFFF);
        divop(ALU_MOD, 16'd5, 16'd0, c3, 16'h0005);
        divop(ALU_DIV, 16'd7, 16'hFFFE, mk_ctrl(1'b0, 16'h0000, 1'b1, 3'd2, 1'b1), 16'hFFFD);
        divop(ALU_MOD, 16'd7, 16'hFFFE, mk_ctrl(1'b0, 16'h0000, 1'b1, 3'd2, 1'b1), 16'h0001);
        bubble();

        // Reset lands on CALC count 5; the partial division must vanish.
        step({ALU_DIV, 16'd100, 16'd7, c3}, 1'b0, 1'b1, 3'd3, ST_IDLE, 38'd0);
        for (int i = 0; i < 5; i++) step(57'd0, 1'b0, 1'b1, 3'd3, ST_CALC, 38'd0);
        step(57'd0, 1'b1, 1'b1, 3'd3, ST_CALC, 38'd0);
        bubble();
        alu(ALU_ADD, 16'd1, 16'd1, mk_ctrl(1'b0, 16'h0000, 1'b1, 3'd1, 1'b0), 16'd2);

        alu(ALU_ADD, 16'h0010, 16'd2, mk_ctrl(1'b1, 16'hBEEF, 1'b0, 3'd0, 1'b0), 16'h0012);
        bubble();
        bubble();

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_cmp  = n_cmp + 1;
            n_fail = n_fail + 1;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
